// File: rtl/active_list_pkg.sv
// rtl/active_list_pkg.sv - shared types and sizes for the active list
package active_list_pkg;

    localparam int ACTIVE_LIST_DEPTH = 16;
    localparam int MIPS_REG_COUNT    = 32;
    localparam int FREE_REG_COUNT    = 32;
    localparam int PHYS_REG_COUNT    = MIPS_REG_COUNT + FREE_REG_COUNT;

    typedef logic [$clog2(MIPS_REG_COUNT)-1:0]    MipsReg;
    typedef logic [$clog2(PHYS_REG_COUNT)-1:0]    PhysReg;
    typedef logic [$clog2(ACTIVE_LIST_DEPTH)-1:0] ActiveIndex;

    typedef struct packed {
        logic   valid;
        PhysReg index;
    } opt_PhysReg;

endpackage

// File: rtl/active_list.sv
// rtl/active_list.sv - in-order retirement queue with mispredict restore
module active_list
    import active_list_pkg::*;
#(
    parameter int DEPTH = ACTIVE_LIST_DEPTH,
    localparam int IW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_alloc_valid,
    output logic          o_alloc_ready,
    input  logic          i_alloc_has_dest,
    input  MipsReg        i_alloc_arch_reg,
    input  PhysReg        i_alloc_new_reg,
    input  PhysReg        i_alloc_old_reg,
    output logic [IW-1:0] o_alloc_index,
    input  logic          i_complete_valid,
    input  logic [IW-1:0] i_complete_index,
    input  logic          i_complete_mispredict,
    output logic          o_commit_valid,
    output MipsReg        o_commit_arch_reg,
    output PhysReg        o_commit_new_reg,
    output opt_PhysReg    o_freed_reg,
    output logic          o_restore,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] done_q;
    logic [DEPTH-1:0] misp_q;
    logic [DEPTH-1:0] dest_q;
    MipsReg           arch_q [DEPTH];
    PhysReg           new_q  [DEPTH];
    PhysReg           old_q  [DEPTH];
    logic [IW-1:0]    head_q;
    logic [IW-1:0]    tail_q;
    logic [CW-1:0]    count_q;

    logic full;
    logic alloc_fire;
    logic complete_fire;

    assign full          = (count_q == CW'(DEPTH));
    assign o_commit_valid = valid_q[head_q] && done_q[head_q];
    assign o_restore     = o_commit_valid && misp_q[head_q];
    assign o_alloc_ready = !full && !o_restore;
    assign alloc_fire    = i_alloc_valid && o_alloc_ready;
    assign complete_fire = i_complete_valid && valid_q[i_complete_index] && !o_restore;

    // Payload outputs are gated so idle and reset states present zeros.
    assign o_commit_arch_reg = o_commit_valid ? arch_q[head_q] : '0;
    assign o_commit_new_reg  = o_commit_valid ? new_q[head_q]  : '0;
    assign o_freed_reg.valid = o_commit_valid && dest_q[head_q];
    assign o_freed_reg.index = o_commit_valid ? old_q[head_q]  : '0;

    assign o_alloc_index = tail_q;
    assign o_empty       = (count_q == '0);
    assign o_count       = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            done_q  <= '0;
            misp_q  <= '0;
            dest_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (o_restore) begin
            // The mispredicted head retires; everything younger is discarded.
            valid_q <= '0;
            head_q  <= head_q + IW'(1);
            tail_q  <= head_q + IW'(1);
            count_q <= '0;
        end else begin
            if (alloc_fire) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                misp_q[tail_q]  <= 1'b0;
                dest_q[tail_q]  <= i_alloc_has_dest;
                tail_q          <= tail_q + IW'(1);
            end
            if (complete_fire) begin
                done_q[i_complete_index] <= 1'b1;
                misp_q[i_complete_index] <= i_complete_mispredict;
            end
            if (o_commit_valid) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + IW'(1);
            end
            case ({alloc_fire, o_commit_valid})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            arch_q[tail_q] <= i_alloc_arch_reg;
            new_q[tail_q]  <= i_alloc_new_reg;
            old_q[tail_q]  <= i_alloc_old_reg;
        end
    end

    // Completing an entry in the cycle it is allocated is an Issue-stage bug.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(alloc_fire && i_complete_valid && i_complete_index == tail_q))
                else $error("active_list: completion of entry %0d in its allocation cycle", tail_q);
        end
    end

endmodule

// File: tb/tb_active_list.sv
// tb/tb_active_list.sv - directed self-checking bench for active_list
module tb_active_list;
    import active_list_pkg::*;

    logic       clk;
    logic       rst;
    logic       alloc_valid;
    logic       alloc_ready;
    logic       alloc_has_dest;
    MipsReg     alloc_arch_reg;
    PhysReg     alloc_new_reg;
    PhysReg     alloc_old_reg;
    ActiveIndex alloc_index;
    logic       complete_valid;
    ActiveIndex complete_index;
    logic       complete_mispredict;
    logic       commit_valid;
    MipsReg     commit_arch_reg;
    PhysReg     commit_new_reg;
    opt_PhysReg freed_reg;
    logic       restore;
    logic       empty;
    logic [4:0] count;

    int checks = 0;
    int passes = 0;

    active_list dut (
        .clk                  (clk),
        .rst                  (rst),
        .i_alloc_valid        (alloc_valid),
        .o_alloc_ready        (alloc_ready),
        .i_alloc_has_dest     (alloc_has_dest),
        .i_alloc_arch_reg     (alloc_arch_reg),
        .i_alloc_new_reg      (alloc_new_reg),
        .i_alloc_old_reg      (alloc_old_reg),
        .o_alloc_index        (alloc_index),
        .i_complete_valid     (complete_valid),
        .i_complete_index     (complete_index),
        .i_complete_mispredict(complete_mispredict),
        .o_commit_valid       (commit_valid),
        .o_commit_arch_reg    (commit_arch_reg),
        .o_commit_new_reg     (commit_new_reg),
        .o_freed_reg          (freed_reg),
        .o_restore            (restore),
        .o_empty              (empty),
        .o_count              (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ready"},  32'(alloc_ready),     32'd1);
        check({tag, "_index"},  32'(alloc_index),     32'd0);
        check({tag, "_empty"},  32'(empty),           32'd1);
        check({tag, "_count"},  32'(count),           32'd0);
        check({tag, "_commit"}, 32'(commit_valid),    32'd0);
        check({tag, "_arch"},   32'(commit_arch_reg), 32'd0);
        check({tag, "_new"},    32'(commit_new_reg),  32'd0);
        check({tag, "_freed"},  32'(freed_reg),       32'd0);
        check({tag, "_restore"},32'(restore),         32'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        #1;
    endtask

    task automatic alloc(input logic hd, input int arch, input int nreg, input int oreg, input int exp_idx, input string tag);
        alloc_valid    = 1'b1;
        alloc_has_dest = hd;
        alloc_arch_reg = MipsReg'(arch);
        alloc_new_reg  = PhysReg'(nreg);
        alloc_old_reg  = PhysReg'(oreg);
        #1;
        check(tag, 32'(alloc_index), 32'(exp_idx));
        cyc();
        alloc_valid    = 1'b0;
        alloc_has_dest = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        alloc_valid = 0; alloc_has_dest = 0; alloc_arch_reg = '0; alloc_new_reg = '0; alloc_old_reg = '0;
        complete_valid = 0; complete_index = '0; complete_mispredict = 0;
        #2;
        check_reset("rst0");
        cyc();
        rst = 1'b0;
        #1;

        // In-order commit of out-of-order completions
        for (int i = 0; i < 3; i++) alloc(1'b1, 5 + i, 32 + i, 1 + i, i, "t1_idx");
        check("t1_count3", 32'(count), 32'd3);
        complete_valid = 1; complete_index = 1; #1;
        check("t1_nocommit_a", 32'(commit_valid), 32'd0);
        cyc();
        complete_index = 0; #1;
        check("t1_nocommit_b", 32'(commit_valid), 32'd0);
        cyc();
        complete_index = 2; #1;
        check("t1_commit0", 32'(commit_valid), 32'd1);
        check("t1_arch0",   32'(commit_arch_reg), 32'd5);
        check("t1_freed0",  32'(freed_reg), 32'h41);
        cyc();
        complete_valid = 0; #1;
        check("t1_freed1",  32'(freed_reg), 32'h42);
        cyc();
        check("t1_freed2",  32'(freed_reg), 32'h43);
        check("t1_new2",    32'(commit_new_reg), 32'd34);
        cyc();
        check("t1_empty",   32'(empty), 32'd1);
        check("t1_count0",  32'(count), 32'd0);

        // Full stall; ready returns only after the commit edge
        pulse_reset();
        for (int i = 0; i < 16; i++) alloc(1'b1, i, 32 + i, i, i, "t2_idx");
        check("t2_count16", 32'(count), 32'd16);
        check("t2_notready", 32'(alloc_ready), 32'd0);
        complete_valid = 1; complete_index = 0; #1;
        cyc();
        complete_valid = 0; alloc_valid = 1; #1;
        check("t2_commit",  32'(commit_valid), 32'd1);
        check("t2_ready_during", 32'(alloc_ready), 32'd0);
        check("t2_freed",   32'(freed_reg), 32'h40);
        cyc();
        alloc_valid = 0; #1;
        check("t2_ready_after", 32'(alloc_ready), 32'd1);
        check("t2_count15", 32'(count), 32'd15);

        // Mispredict at entry 2 with six entries live
        pulse_reset();
        for (int i = 0; i < 6; i++) alloc(1'b1, i, 40 + i, 10 + i, i, "t3_idx");
        complete_valid = 1; complete_index = 0; cyc();
        complete_index = 1; cyc();
        complete_index = 2; complete_mispredict = 1; #1;
        check("t3_commit1",   32'(commit_valid), 32'd1);
        check("t3_norestore", 32'(restore), 32'd0);
        check("t3_freed1",    32'(freed_reg), 32'h4B);
        cyc();
        complete_valid = 0; complete_mispredict = 0; alloc_valid = 1; #1;
        check("t3_restore",   32'(restore), 32'd1);
        check("t3_freed2",    32'(freed_reg), 32'h4C);
        check("t3_new2",      32'(commit_new_reg), 32'd42);
        check("t3_ready_low", 32'(alloc_ready), 32'd0);
        cyc();
        alloc_valid = 0; #1;
        check("t3_count0",    32'(count), 32'd0);
        check("t3_empty",     32'(empty), 32'd1);
        check("t3_tail3",     32'(alloc_index), 32'd3);
        check("t3_restore_off", 32'(restore), 32'd0);
        alloc(1'b1, 9, 50, 20, 3, "t3_realloc");
        complete_valid = 1; complete_index = 3; cyc();
        complete_valid = 0; #1;
        check("t3_head3_commit", 32'(commit_valid), 32'd1);
        check("t3_head3_new",    32'(commit_new_reg), 32'd50);
        cyc();

        // Wrap-around with every third instruction lacking a destination
        pulse_reset();
        for (int i = 0; i < 40; i++) begin
            logic hd;
            hd = (i % 3) != 2;
            alloc(hd, i % 32, i + 20, i, i % 16, "t4_idx");
            complete_valid = 1; complete_index = ActiveIndex'(i % 16); cyc();
            complete_valid = 0; #1;
            check("t4_freed", 32'(freed_reg), {25'd0, hd, 6'(i)});
            cyc();
        end
        check("t4_empty", 32'(empty), 32'd1);

        // Asynchronous reset mid-stream
        pulse_reset();
        for (int i = 0; i < 7; i++) alloc(1'b1, i, 32 + i, i, i, "t5_idx");
        complete_valid = 1; complete_index = 0; cyc();
        complete_valid = 0; #1;
        check("t5_commit_pre", 32'(commit_valid), 32'd1);
        check("t5_count_pre",  32'(count), 32'd7);
        rst = 1'b1; #1;
        check_reset("t5_rst");
        rst = 1'b0; #1;
        alloc(1'b1, 3, 60, 4, 0, "t5_idx0");
        check("t5_count1", 32'(count), 32'd1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
